// File: rtl/dec_trigger_pipe_pkg.sv
// Shared types for the execute-trigger pipe: per-stage packet, wb packet and the
// pair-chain resolve helper. NTRIG lives here so every user agrees on the vector widths.
package dec_trigger_pipe_pkg;

  // Number of triggers; must be even, pairs {0,1},{2,3},... may chain.
  localparam int unsigned NTRIG = 4;
  localparam int unsigned NPAIR = NTRIG / 2;

  // One pipe stage worth of trigger state for both issue slots.
  typedef struct packed {
    logic             i0_v;
    logic             i1_v;
    logic [NTRIG-1:0] i0_match;
    logic [NTRIG-1:0] i1_match;
  } trig_pipe_pkt_t;

  // Resolved trigger state held at wb.
  typedef struct packed {
    logic [NTRIG-1:0] i0_trig;
    logic [NTRIG-1:0] i1_trig;
    logic             dbg;
    logic             bkpt;
  } trig_wb_pkt_t;

  // A chained pair only fires when both members match; unchained bits pass through.
  function automatic logic [NTRIG-1:0] chain_resolve(logic [NTRIG-1:0] m,
                                                     logic [NPAIR-1:0] chain);
    logic [NTRIG-1:0] r;
    r = m;
    for (int unsigned k = 0; k < NPAIR; k++) begin
      if (chain[k]) begin
        r[2*k]   = m[2*k] & m[2*k+1];
        r[2*k+1] = m[2*k] & m[2*k+1];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_trigger_pipe_if.sv
// Decode/TLU side signals of the trigger pipe. master = decode/TLU driving the pipe,
// slave = the pipe itself.
interface dec_trigger_pipe_if;
  import dec_trigger_pipe_pkg::*;

  logic [NTRIG-1:0] dec_i0_trigger_match_d;
  logic [NTRIG-1:0] dec_i1_trigger_match_d;
  logic             dec_i0_valid_d;
  logic             dec_i1_valid_d;
  logic             dec_freeze;
  logic             dec_flush_upper_e2;
  logic             dec_tlu_flush_lower_wb;
  logic [NPAIR-1:0] trigger_chain;
  logic [NTRIG-1:0] trigger_action;

  logic [NTRIG-1:0] dec_tlu_i0_trigger_wb;
  logic [NTRIG-1:0] dec_tlu_i1_trigger_wb;
  logic             dec_tlu_trigger_dbg_wb;
  logic             dec_tlu_trigger_bkpt_wb;
  logic [NTRIG-1:0] dec_tlu_trigger_hit_set_wb;

  modport master (
    output dec_i0_trigger_match_d, dec_i1_trigger_match_d, dec_i0_valid_d, dec_i1_valid_d,
           dec_freeze, dec_flush_upper_e2, dec_tlu_flush_lower_wb, trigger_chain,
           trigger_action,
    input  dec_tlu_i0_trigger_wb, dec_tlu_i1_trigger_wb, dec_tlu_trigger_dbg_wb,
           dec_tlu_trigger_bkpt_wb, dec_tlu_trigger_hit_set_wb
  );

  modport slave (
    input  dec_i0_trigger_match_d, dec_i1_trigger_match_d, dec_i0_valid_d, dec_i1_valid_d,
           dec_freeze, dec_flush_upper_e2, dec_tlu_flush_lower_wb, trigger_chain,
           trigger_action,
    output dec_tlu_i0_trigger_wb, dec_tlu_i1_trigger_wb, dec_tlu_trigger_dbg_wb,
           dec_tlu_trigger_bkpt_wb, dec_tlu_trigger_hit_set_wb
  );

endinterface

// File: rtl/dec_trigger_chain.sv
// Combinational resolve at e4: pair chaining, i0-over-i1 slot priority and
// debug-vs-breakpoint action selection.
module dec_trigger_chain
  import dec_trigger_pipe_pkg::*;
(
  input  trig_pipe_pkt_t   pkt,
  input  logic [NPAIR-1:0] chain,
  input  logic [NTRIG-1:0] action,
  output logic [NTRIG-1:0] i0_fired,
  output logic [NTRIG-1:0] i1_fired,
  output logic             dbg,
  output logic             bkpt
);

  logic [NTRIG-1:0] i0_res;
  logic [NTRIG-1:0] i1_res;
  logic [NTRIG-1:0] fired;

  // Resolve chains per slot, then let an i0 fire block i1 from retiring.
  always_comb begin
    i0_res   = chain_resolve(pkt.i0_match & {NTRIG{pkt.i0_v}}, chain);
    i1_res   = chain_resolve(pkt.i1_match & {NTRIG{pkt.i1_v}}, chain);
    i0_fired = i0_res;
    i1_fired = (|i0_res) ? '0 : i1_res;
    fired    = i0_fired | i1_fired;
    dbg      = |(fired & action);
    bkpt     = (|fired) & ~dbg;
  end

endmodule

// File: rtl/dec_trigger_pipe.sv
// Carries execute-trigger matches from decode through e1..e4 to wb, honouring freeze and
// both flushes, resolves chains/priority/action at e4 and drives the TLU from wb.
module dec_trigger_pipe
  import dec_trigger_pipe_pkg::*;
(
  input logic               clk,
  input logic               rst_l,
  dec_trigger_pipe_if.slave bus
);

  trig_pipe_pkt_t d_pkt;
  trig_pipe_pkt_t e1_d, e1_q;
  trig_pipe_pkt_t e2_d, e2_q;
  trig_pipe_pkt_t e3_d, e3_q;
  trig_pipe_pkt_t e4_d, e4_q;
  trig_wb_pkt_t   wb_d, wb_q;
  logic           first_d, first_q;

  logic             flush_lower;
  logic             kill_upper;
  logic             en_upper;
  logic             en_lower;
  logic [NTRIG-1:0] e4_i0_fired;
  logic [NTRIG-1:0] e4_i1_fired;
  logic             e4_dbg;
  logic             e4_bkpt;

  assign flush_lower = bus.dec_tlu_flush_lower_wb;
  assign kill_upper  = bus.dec_flush_upper_e2 | flush_lower;
  // Flushes override freeze so killed stages always clear.
  assign en_upper    = ~bus.dec_freeze | kill_upper;
  assign en_lower    = ~bus.dec_freeze | flush_lower;

  dec_trigger_chain u_chain (
    .pkt      (e4_q),
    .chain    (bus.trigger_chain),
    .action   (bus.trigger_action),
    .i0_fired (e4_i0_fired),
    .i1_fired (e4_i1_fired),
    .dbg      (e4_dbg),
    .bkpt     (e4_bkpt)
  );

  // Next-state for each stage; contents of e1/e2 die on either flush, so e3 takes zero too.
  always_comb begin
    d_pkt.i0_v     = bus.dec_i0_valid_d;
    d_pkt.i1_v     = bus.dec_i1_valid_d;
    d_pkt.i0_match = bus.dec_i0_trigger_match_d & {NTRIG{bus.dec_i0_valid_d}};
    d_pkt.i1_match = bus.dec_i1_trigger_match_d & {NTRIG{bus.dec_i1_valid_d}};

    e1_d = kill_upper ? '0 : d_pkt;
    e2_d = kill_upper ? '0 : e1_q;
    e3_d = kill_upper ? '0 : e2_q;
    e4_d = flush_lower ? '0 : e3_q;

    wb_d         = '0;
    if (!flush_lower) begin
      wb_d.i0_trig = e4_i0_fired;
      wb_d.i1_trig = e4_i1_fired;
      wb_d.dbg     = e4_dbg;
      wb_d.bkpt    = e4_bkpt;
    end

    // Only a freshly loaded wb entry may pulse hit_set.
    first_d = en_lower & ~flush_lower;
  end

  // Stage registers with freeze-hold enables.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      e1_q    <= '0;
      e2_q    <= '0;
      e3_q    <= '0;
      e4_q    <= '0;
      wb_q    <= '0;
      first_q <= 1'b0;
    end else begin
      if (en_upper) begin
        e1_q <= e1_d;
        e2_q <= e2_d;
      end
      if (en_lower) begin
        e3_q <= e3_d;
        e4_q <= e4_d;
        wb_q <= wb_d;
      end
      first_q <= first_d;
    end
  end

  assign bus.dec_tlu_i0_trigger_wb      = wb_q.i0_trig;
  assign bus.dec_tlu_i1_trigger_wb      = wb_q.i1_trig;
  assign bus.dec_tlu_trigger_dbg_wb     = wb_q.dbg;
  assign bus.dec_tlu_trigger_bkpt_wb    = wb_q.bkpt;
  assign bus.dec_tlu_trigger_hit_set_wb = first_q ? (wb_q.i0_trig | wb_q.i1_trig) : '0;

endmodule

// File: tb/tb_dec_trigger_pipe.sv
// Bench for dec_trigger_pipe: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against an instruction-level model.
module tb_dec_trigger_pipe;
  import dec_trigger_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_l;

  dec_trigger_pipe_if bus ();

  dec_trigger_pipe dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what each in-flight instruction matched, indexed by position e1..e4.
  typedef struct {
    logic [NTRIG-1:0] i0;
    logic [NTRIG-1:0] i1;
  } mslot_t;

  mslot_t           m_pipe [4];
  logic [NTRIG-1:0] m_i0, m_i1;
  logic             m_dbg, m_bkpt, m_fresh;

  task automatic chk(string name, logic [NTRIG-1:0] act, logic [NTRIG-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NTRIG-1:0] m_chain(logic [NTRIG-1:0] m, logic [NPAIR-1:0] ch);
    logic [NTRIG-1:0] r;
    for (int i = 0; i < NTRIG; i++) r[i] = ch[i/2] ? (m[i] & m[i^1]) : m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_pipe[s] = '{'0, '0};
    m_i0 = '0; m_i1 = '0; m_dbg = 1'b0; m_bkpt = 1'b0; m_fresh = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [NTRIG-1:0] d0, d1, r0, r1, fired;
    logic f, fu;
    f  = bus.dec_freeze;
    fu = bus.dec_flush_upper_e2;
    d0 = bus.dec_i0_valid_d ? bus.dec_i0_trigger_match_d : '0;
    d1 = bus.dec_i1_valid_d ? bus.dec_i1_trigger_match_d : '0;
    if (bus.dec_tlu_flush_lower_wb) begin
      model_reset();
    end else begin
      if (!f) begin
        r0 = m_chain(m_pipe[3].i0, bus.trigger_chain);
        r1 = m_chain(m_pipe[3].i1, bus.trigger_chain);
        if (r0 != '0) r1 = '0;
        fired   = r0 | r1;
        m_i0    = r0;
        m_i1    = r1;
        m_dbg   = (fired & bus.trigger_action) != '0;
        m_bkpt  = (fired != '0) && !m_dbg;
        m_fresh = 1'b1;
        for (int s = 3; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = '{d0, d1};
      end else begin
        m_fresh = 1'b0;
      end
      // Instructions sitting in e1/e2 at the flush are gone.
      if (fu) begin
        m_pipe[0] = '{'0, '0};
        m_pipe[1] = '{'0, '0};
        if (!f) m_pipe[2] = '{'0, '0};
      end
    end
  endtask

  task automatic compare_all();
    chk("i0_wb", bus.dec_tlu_i0_trigger_wb, m_i0);
    chk("i1_wb", bus.dec_tlu_i1_trigger_wb, m_i1);
    chk("dbg_wb", NTRIG'(bus.dec_tlu_trigger_dbg_wb), NTRIG'(m_dbg));
    chk("bkpt_wb", NTRIG'(bus.dec_tlu_trigger_bkpt_wb), NTRIG'(m_bkpt));
    chk("hit_set_wb", bus.dec_tlu_trigger_hit_set_wb, m_fresh ? (m_i0 | m_i1) : '0);
  endtask

  // Inputs are already set; clock once and compare at the following falling edge.
  task automatic cycle();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(logic [NTRIG-1:0] m0, logic [NTRIG-1:0] m1);
    bus.dec_i0_trigger_match_d = m0;
    bus.dec_i1_trigger_match_d = m1;
    bus.dec_i0_valid_d         = (m0 != '0);
    bus.dec_i1_valid_d         = (m1 != '0);
  endtask

  task automatic idle();
    drive('0, '0);
    bus.dec_freeze             = 1'b0;
    bus.dec_flush_upper_e2     = 1'b0;
    bus.dec_tlu_flush_lower_wb = 1'b0;
  endtask

  initial begin
    rst_l              = 1'b0;
    idle();
    bus.trigger_chain  = '0;
    bus.trigger_action = '0;
    model_reset();
    @(negedge clk);
    compare_all();
    chk("rst_i0", bus.dec_tlu_i0_trigger_wb, 4'b0000);
    chk("rst_hit", bus.dec_tlu_trigger_hit_set_wb, 4'b0000);
    rst_l = 1'b1;
    @(negedge clk);

    // Single unchained breakpoint trigger: five-cycle latency, one-cycle pulse.
    drive(4'b0001, '0); cycle();
    idle(); repeat (3) cycle();
    chk("s1_early_i0", bus.dec_tlu_i0_trigger_wb, 4'b0000);
    cycle();
    chk("s1_i0", bus.dec_tlu_i0_trigger_wb, 4'b0001);
    chk("s1_bkpt", NTRIG'(bus.dec_tlu_trigger_bkpt_wb), 4'b0001);
    chk("s1_dbg", NTRIG'(bus.dec_tlu_trigger_dbg_wb), 4'b0000);
    chk("s1_hit", bus.dec_tlu_trigger_hit_set_wb, 4'b0001);
    cycle();
    chk("s1_after_i0", bus.dec_tlu_i0_trigger_wb, 4'b0000);
    chk("s1_after_hit", bus.dec_tlu_trigger_hit_set_wb, 4'b0000);

    // Chained pair: half a pair is nothing, both halves fire together.
    bus.trigger_chain = 2'b01;
    drive(4'b0001, '0); cycle();
    idle(); repeat (4) cycle();
    chk("s2_half_i0", bus.dec_tlu_i0_trigger_wb, 4'b0000);
    chk("s2_half_bkpt", NTRIG'(bus.dec_tlu_trigger_bkpt_wb), 4'b0000);
    drive(4'b0011, '0); cycle();
    idle(); repeat (4) cycle();
    chk("s2_pair_i0", bus.dec_tlu_i0_trigger_wb, 4'b0011);
    chk("s2_pair_hit", bus.dec_tlu_trigger_hit_set_wb, 4'b0011);

    // i0 priority over i1, debug action.
    bus.trigger_chain  = '0;
    bus.trigger_action = 4'b0100;
    drive(4'b0100, 4'b1000); cycle();
    idle(); repeat (4) cycle();
    chk("s3_i0", bus.dec_tlu_i0_trigger_wb, 4'b0100);
    chk("s3_i1", bus.dec_tlu_i1_trigger_wb, 4'b0000);
    chk("s3_dbg", NTRIG'(bus.dec_tlu_trigger_dbg_wb), 4'b0001);
    chk("s3_bkpt", NTRIG'(bus.dec_tlu_trigger_bkpt_wb), 4'b0000);

    // Upper flush kills e2 but not e3.
    bus.trigger_action = '0;
    drive(4'b0001, '0); cycle();
    drive(4'b0010, '0); cycle();
    idle(); cycle();
    bus.dec_flush_upper_e2 = 1'b1; cycle();
    idle(); cycle();
    chk("s4_e3_i0", bus.dec_tlu_i0_trigger_wb, 4'b0001);
    cycle();
    chk("s4_e2_killed", bus.dec_tlu_i0_trigger_wb, 4'b0000);
    cycle();

    // Freeze holds wb without repeating the pulse; lower flush beats freeze.
    drive(4'b0100, '0); cycle();
    idle(); repeat (4) cycle();
    chk("s5_i0", bus.dec_tlu_i0_trigger_wb, 4'b0100);
    chk("s5_hit", bus.dec_tlu_trigger_hit_set_wb, 4'b0100);
    bus.dec_freeze = 1'b1;
    repeat (3) begin
      cycle();
      chk("s5_hold_i0", bus.dec_tlu_i0_trigger_wb, 4'b0100);
      chk("s5_hold_hit", bus.dec_tlu_trigger_hit_set_wb, 4'b0000);
    end
    bus.dec_tlu_flush_lower_wb = 1'b1; cycle();
    chk("s5_flush_i0", bus.dec_tlu_i0_trigger_wb, 4'b0000);
    idle(); cycle();

    // Asynchronous reset with a full pipe.
    repeat (6) begin drive(4'b0001, '0); cycle(); end
    rst_l = 1'b0;
    #1;
    chk("s6_rst_i0", bus.dec_tlu_i0_trigger_wb, 4'b0000);
    chk("s6_rst_bkpt", NTRIG'(bus.dec_tlu_trigger_bkpt_wb), 4'b0000);
    model_reset();
    idle();
    @(negedge clk);
    rst_l = 1'b1;
    repeat (5) cycle();
    chk("s6_stale_i0", bus.dec_tlu_i0_trigger_wb, 4'b0000);
    chk("s6_stale_hit", bus.dec_tlu_trigger_hit_set_wb, 4'b0000);

    // Randomized traffic against the model.
    repeat (800) begin
      bus.dec_i0_valid_d         = ($urandom_range(9) < 7);
      bus.dec_i1_valid_d         = ($urandom_range(9) < 7);
      bus.dec_i0_trigger_match_d = NTRIG'($urandom & $urandom);
      bus.dec_i1_trigger_match_d = NTRIG'($urandom & $urandom);
      bus.dec_freeze             = ($urandom_range(9) < 2);
      bus.dec_flush_upper_e2     = ($urandom_range(19) == 0);
      bus.dec_tlu_flush_lower_wb = ($urandom_range(24) == 0);
      if ($urandom_range(15) == 0) begin
        bus.trigger_chain  = NPAIR'($urandom);
        bus.trigger_action = NTRIG'($urandom);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
